// File: rtl/ascon_pack.sv
// Shared types and widths for the Ascon host-side loader path.
// Host words are 32 bits; wrapper FIFOs carry 64-bit blocks.
package ascon_pack;

  localparam int HOST_WIDTH  = 32;
  localparam int BLOCK_WIDTH = 64;

  typedef logic [HOST_WIDTH-1:0]  u32_t;
  typedef logic [BLOCK_WIDTH-1:0] u64_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AD   = 2'd1,
    PT   = 2'd2,
    DONE = 2'd3
  } loader_state_e;

  // Little-endian host words arrive with byte 0 in the low lane.
  function automatic u32_t byte_swap(input u32_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ascon_word_packer.sv
// Packs pairs of 32-bit host words into one 64-bit block, first word high.
// Optional byte reversal of each host word when ASCON_LOADER_BSWAP_EN is defined.
module ascon_word_packer
  import ascon_pack::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic s_valid,
  input  u32_t s_data,
  input  logic full,
  output logic s_ready,
  output logic push,
  output u64_t block
);

  u32_t word;
  u32_t hold;
  logic half;

`ifdef ASCON_LOADER_BSWAP_EN
  assign word = byte_swap(s_data);
`else
  assign word = s_data;
`endif

  // The first word is always taken; only the completing word waits on full.
  assign s_ready = enable && !rst && (!half || !full);
  assign push    = s_ready && s_valid && half;
  assign block   = {hold, word};

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      half <= 1'b0;
    end else if (s_ready && s_valid) begin
      if (!half) begin
        hold <= word;
        half <= 1'b1;
      end else begin
        half <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ascon_loader.sv
// Host-to-Ascon loader: issues the core start, then fills the AD and PT FIFOs
// from the 32-bit host stream. Byte swap option: ASCON_LOADER_BSWAP_EN.
//
// state | meaning
// IDLE  | waiting for start_i with ascon_ready_i
// AD    | packing words into AD FIFO blocks
// PT    | packing words into PT FIFO blocks
// DONE  | done_o pulse, busy_o drops next cycle
module ascon_loader
  import ascon_pack::*;
#(
  parameter int DATA_AW = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_AW-1:0] ad_size_i,
  input  logic [DATA_AW-1:0] pt_size_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               s_valid_i,
  input  logic [31:0]        s_data_i,
  output logic               s_ready_o,
  input  logic               ascon_ready_i,
  output logic               ascon_start_o,
  output logic               ad_push_o,
  output logic [63:0]        ad_o,
  input  logic               ad_full_i,
  output logic               pt_push_o,
  output logic [63:0]        pt_o,
  input  logic               pt_full_i
);

  localparam logic [DATA_AW-1:0] CNT_ONE = 1;

  loader_state_e      state;
  logic [DATA_AW-1:0] ad_cnt;
  logic [DATA_AW-1:0] pt_cnt;
  logic               busy;
  logic               done;

  logic start_ok;
  logic active;
  logic sel_full;
  logic pk_ready;
  logic pk_push;
  u64_t block;

  assign active   = (state == AD) || (state == PT);
  assign sel_full = (state == PT) ? pt_full_i : ad_full_i;
  assign start_ok = (state == IDLE) && start_i && ascon_ready_i && !rst;

  ascon_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .enable  (active),
    .s_valid (s_valid_i),
    .s_data  (s_data_i),
    .full    (sel_full),
    .s_ready (pk_ready),
    .push    (pk_push),
    .block   (block)
  );

  assign ascon_start_o = start_ok;
  assign s_ready_o     = pk_ready;
  assign ad_push_o     = pk_push && (state == AD);
  assign pt_push_o     = pk_push && (state == PT);
  assign ad_o          = ad_push_o ? block : '0;
  assign pt_o          = pt_push_o ? block : '0;
  assign busy_o        = busy;
  assign done_o        = done;

  // Counters hold blocks still to push; leaving a phase happens on 1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ad_cnt <= '0;
      pt_cnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            ad_cnt <= ad_size_i;
            pt_cnt <= pt_size_i;
            busy   <= 1'b1;
            if (ad_size_i != '0) begin
              state <= AD;
            end else if (pt_size_i != '0) begin
              state <= PT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        AD: begin
          if (pk_push) begin
            ad_cnt <= ad_cnt - CNT_ONE;
            if (ad_cnt == CNT_ONE) begin
              if (pt_cnt != '0) begin
                state <= PT;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        PT: begin
          if (pk_push) begin
            pt_cnt <= pt_cnt - CNT_ONE;
            if (pt_cnt == CNT_ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_loader.sv
// Self-checking bench for ascon_loader: directed loads plus randomized host
// stream and FIFO-full patterns against a word-index reference model.
module tb_ascon_loader;
  import ascon_pack::*;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ad_size_i;
  logic [AW-1:0] pt_size_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          s_valid_i;
  logic [31:0]   s_data_i;
  logic          s_ready_o;
  logic          ascon_ready_i;
  logic          ascon_start_o;
  logic          ad_push_o;
  logic [63:0]   ad_o;
  logic          ad_full_i;
  logic          pt_push_o;
  logic [63:0]   pt_o;
  logic          pt_full_i;

  ascon_loader #(.DATA_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ad_size_i     (ad_size_i),
    .pt_size_i     (pt_size_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .ascon_ready_i (ascon_ready_i),
    .ascon_start_o (ascon_start_o),
    .ad_push_o     (ad_push_o),
    .ad_o          (ad_o),
    .ad_full_i     (ad_full_i),
    .pt_push_o     (pt_push_o),
    .pt_o          (pt_o),
    .pt_full_i     (pt_full_i)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  u32_t fixed_q[$];
  u64_t last_ad;
  u64_t last_pt;
  int   stall_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic u32_t host_word(input u32_t w);
`ifdef ASCON_LOADER_BSWAP_EN
    return {<<8{w}};
`else
    return w;
`endif
  endfunction

  // Model: word k of the load belongs to block k/2, which is AD while k/2 < ad_n.
  task automatic do_load(input int ad_n, input int pt_n, input int hold_off,
                         input bit rnd_valid, input bit rnd_full, input bit stall);
    u32_t words[$];
    u64_t exp_blk[$];
    int   total, k, c, last_ev;
    bit   to_ad, full_sel, exp_ready, accepted, exp_push, finished;
    total = 2 * (ad_n + pt_n);
    for (int i = 0; i < total; i++)
      words.push_back((fixed_q.size() > 0) ? fixed_q.pop_front() : u32_t'($urandom));
    for (int b = 0; b < ad_n + pt_n; b++)
      exp_blk.push_back({host_word(words[2*b]), host_word(words[2*b+1])});
    stall_n = 0;

    for (int i = 0; i < hold_off; i++) begin
      @(negedge clk);
      start_i = 1'b1; ascon_ready_i = 1'b0;
      ad_size_i = AW'(ad_n); pt_size_i = AW'(pt_n);
      #1;
      check("holdoff_start", 64'(ascon_start_o), 64'(0));
      check("holdoff_busy", 64'(busy_o), 64'(0));
    end

    @(negedge clk);
    start_i = 1'b1; ascon_ready_i = 1'b1;
    ad_size_i = AW'(ad_n); pt_size_i = AW'(pt_n);
    s_valid_i = 1'b1; s_data_i = $urandom; ad_full_i = 1'b0; pt_full_i = 1'b0;
    #1;
    check("start_pulse", 64'(ascon_start_o), 64'(1));
    check("idle_ready", 64'(s_ready_o), 64'(0));
    check("busy_before", 64'(busy_o), 64'(0));
    check("idle_push", 64'({ad_push_o, pt_push_o}), 64'(0));

    k = 0;
    last_ev = (total == 0) ? 0 : -1;
    c = 1;
    finished = 1'b0;
    while (!finished && c < 2000) begin
      @(negedge clk);
      start_i       = 1'($urandom_range(0, 1));
      ascon_ready_i = 1'($urandom_range(0, 1));
      ad_size_i     = AW'($urandom);
      pt_size_i     = AW'($urandom);
      s_valid_i     = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i      = (k < total) ? words[k] : $urandom;
      ad_full_i     = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
      pt_full_i     = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (stall && k == 1 && stall_n < 5) begin
        ad_full_i = 1'b1;
        stall_n++;
      end
      #1;
      to_ad     = (k / 2) < ad_n;
      full_sel  = to_ad ? ad_full_i : pt_full_i;
      exp_ready = (k < total) && ((k % 2 == 0) || !full_sel);
      accepted  = s_valid_i && exp_ready;
      exp_push  = accepted && (k % 2 == 1);
      check("s_ready", 64'(s_ready_o), 64'(exp_ready));
      check("ad_push", 64'(ad_push_o), 64'(exp_push && to_ad));
      check("pt_push", 64'(pt_push_o), 64'(exp_push && !to_ad));
      check("start_quiet", 64'(ascon_start_o), 64'(0));
      check("busy", 64'(busy_o), 64'(1));
      check("done", 64'(done_o), 64'(last_ev >= 0 && c == last_ev + 1));
      if (exp_push && to_ad) begin
        check("ad_data", ad_o, exp_blk[k/2]);
        last_ad = ad_o;
      end
      if (exp_push && !to_ad) begin
        check("pt_data", pt_o, exp_blk[k/2]);
        last_pt = pt_o;
      end
      if (last_ev >= 0 && c == last_ev + 1) finished = 1'b1;
      if (accepted) begin
        k++;
        if (k == total) last_ev = c;
      end
      c++;
    end
    if (!finished) check("timeout", 64'(0), 64'(1));

    @(negedge clk);
    start_i = 1'b0; ascon_ready_i = 1'b0; s_valid_i = 1'b1;
    ad_full_i = 1'b0; pt_full_i = 1'b0;
    #1;
    check("busy_after", 64'(busy_o), 64'(0));
    check("done_after", 64'(done_o), 64'(0));
    check("ready_after", 64'(s_ready_o), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; ascon_ready_i = 1'b0; s_valid_i = 1'b0;
    s_data_i = '0; ad_size_i = '0; pt_size_i = '0; ad_full_i = 1'b0; pt_full_i = 1'b0;
    last_ad = '0; last_pt = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_ready", 64'(s_ready_o), 64'(0));
    check("rst_start", 64'(ascon_start_o), 64'(0));
    check("rst_push", 64'({ad_push_o, pt_push_o}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Known vectors: AD then PT block, byte-reversed inputs when swap is built in.
`ifdef ASCON_LOADER_BSWAP_EN
    fixed_q = '{32'h67452301, 32'hEFCDAB89, 32'hEFBEADDE, 32'hEEFFC000};
`else
    fixed_q = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h00C0FFEE};
`endif
    do_load(1, 1, 0, 1'b0, 1'b0, 1'b0);
    check("vec_ad", last_ad, 64'h0123456789ABCDEF);
    check("vec_pt", last_pt, 64'hDEADBEEF00C0FFEE);

    do_load(0, 2, 0, 1'b0, 1'b0, 1'b0);
    do_load(0, 0, 0, 1'b0, 1'b0, 1'b0);

    do_load(2, 1, 0, 1'b0, 1'b0, 1'b1);
    check("stall_len", 64'(stall_n), 64'(5));

    do_load(1, 2, 3, 1'b1, 1'b0, 1'b0);

    // Reset with half a PT block held.
    @(negedge clk);
    start_i = 1'b1; ascon_ready_i = 1'b1; ad_size_i = AW'(0); pt_size_i = AW'(1);
    #1;
    check("mid_start", 64'(ascon_start_o), 64'(1));
    @(negedge clk);
    start_i = 1'b0; s_valid_i = 1'b1; s_data_i = $urandom;
    #1;
    check("mid_first_ready", 64'(s_ready_o), 64'(1));
    @(negedge clk);
    rst = 1'b1; s_data_i = $urandom;
    #1;
    check("mid_rst_ready", 64'(s_ready_o), 64'(0));
    check("mid_rst_push", 64'({ad_push_o, pt_push_o}), 64'(0));
    check("mid_rst_pt", pt_o, 64'(0));
    check("mid_rst_start", 64'(ascon_start_o), 64'(0));
    @(negedge clk);
    rst = 1'b0; s_valid_i = 1'b0;
    #1;
    check("post_rst_busy", 64'(busy_o), 64'(0));
    check("post_rst_done", 64'(done_o), 64'(0));
    check("post_rst_ready", 64'(s_ready_o), 64'(0));
    do_load(0, 1, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++)
      do_load($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2),
              1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
